cla_add_arbiter: RTL and testbench

CLA_ADD_ARBITER -- requirements
Module: cla_add_arbiter

---
 rtl/cla_arb_pkg.sv | 14 +
 rtl/cla_cout_w.sv | 44 ++++
 rtl/cla_add_arbiter.sv | 137 +++++++++++++
 tb/tb_cla_add_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_arb_pkg.sv
// rtl/cla_arb_pkg.sv - shared defaults, state encoding and counter width for the adder arbiter
package cla_arb_pkg;

    localparam int NREQ_DEFAULT = 4;
    localparam int W_DEFAULT    = 6;
    localparam int OPS_W        = 16;

    // Result slot occupancy; the encoding doubles as res_valid.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/cla_cout_w.sv
// rtl/cla_cout_w.sv - W-bit carry-lookahead adder, carry-in tied to zero
// Ports:
//   a_i, b_i : operands
//   sum_o    : (a_i + b_i) mod 2^W
//   cout_o   : carry out of bit W-1
module cla_cout_w #(
    parameter int W = 6
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Every carry is a flat sum of generate terms propagated through the
    // bits above them, so no carry depends on a lower carry signal.
    always_comb begin
        logic term;
        logic prod;
        c = '0;
        for (int i = 0; i < W; i++) begin
            term = 1'b0;
            for (int j = 0; j <= i; j++) begin
                prod = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    prod = prod & p[k];
                end
                term = term | prod;
            end
            c[i+1] = term;
        end
    end

    assign sum_o  = p ^ c[W-1:0];
    assign cout_o = c[W];

endmodule

// File: rtl/cla_add_arbiter.sv
// rtl/cla_add_arbiter.sv - round-robin arbiter sharing one CLA adder among NREQ requesters
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   req_valid/req_a/req_b        : per-requester operand pairs (packed, W bits each)
//   req_ready                    : one-hot combinational grant
//   res_valid/res_sum/res_cout/res_id, res_ready : registered result handshake
//   ops_count                    : completed transfer count (wraps)
module cla_add_arbiter
    import cla_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int W    = W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*W-1:0]         req_a,
    input  logic [NREQ*W-1:0]         req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic                      res_valid,
    output logic [W-1:0]              res_sum,
    output logic                      res_cout,
    output logic [$clog2(NREQ)-1:0]   res_id,
    input  logic                      res_ready,
    output logic [OPS_W-1:0]          ops_count
);

    localparam int IDW = $clog2(NREQ);

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [OPS_W-1:0] ops_q, ops_d;

    logic [IDW-1:0]  winner;
    logic            found;
    logic            slot_free;
    logic            xfer;
    logic [W-1:0]    mux_a, mux_b;
    logic [W-1:0]    add_sum;
    logic            add_cout;

    // Round-robin search starting at rr_ptr_q, wrapping at NREQ.
    always_comb begin
        logic [IDW:0]   pos;
        logic [IDW-1:0] idx;
        found  = 1'b0;
        winner = '0;
        for (int off = 0; off < NREQ; off++) begin
            pos = {1'b0, rr_ptr_q} + (IDW+1)'(off);
            if (pos >= (IDW+1)'(NREQ)) begin
                pos = pos - (IDW+1)'(NREQ);
            end
            idx = pos[IDW-1:0];
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // A pending result can be replaced in the cycle it is consumed.
    assign slot_free = (state_q == ST_EMPTY) || res_ready;
    assign xfer      = found && slot_free && !rst;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = xfer && (winner == IDW'(i));
        end
    end

    assign mux_a = req_a[winner*W +: W];
    assign mux_b = req_b[winner*W +: W];

    cla_cout_w #(
        .W (W)
    ) u_adder (
        .a_i    (mux_a),
        .b_i    (mux_b),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        logic [IDW:0] nxt;
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        id_d     = id_q;
        ops_d    = ops_q;
        nxt      = {1'b0, winner} + (IDW+1)'(1);
        if (nxt == (IDW+1)'(NREQ)) begin
            nxt = '0;
        end
        if (xfer) begin
            rr_ptr_d = nxt[IDW-1:0];
            sum_d    = add_sum;
            cout_d   = add_cout;
            id_d     = winner;
            ops_d    = ops_q + OPS_W'(1);
        end
        case (state_q)
            ST_EMPTY: if (xfer) state_d = ST_FULL;
            ST_FULL:  if (res_ready && !xfer) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            rr_ptr_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            id_q     <= '0;
            ops_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            id_q     <= id_d;
            ops_q    <= ops_d;
        end
    end

    assign res_valid = (state_q == ST_FULL);
    assign res_sum   = sum_q;
    assign res_cout  = cout_q;
    assign res_id    = id_q;
    assign ops_count = ops_q;

endmodule

// File: tb/tb_cla_add_arbiter.sv
// tb/tb_cla_add_arbiter.sv - self-checking bench for cla_add_arbiter
module tb_cla_add_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [23:0] req_a;
    logic [23:0] req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic [5:0]  res_sum;
    logic        res_cout;
    logic [1:0]  res_id;
    logic        res_ready;
    logic [15:0] ops_count;

    int n_chk;
    int n_fail;

    cla_add_arbiter #(.NREQ(4), .W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id),
        .res_ready (res_ready),
        .ops_count (ops_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [23:0] a;
        logic [23:0] b;
        logic        ready;
        logic [3:0]  erdy;
        logic        erv;
        logic        chk_data;
        logic [5:0]  esum;
        logic        ecout;
        logic [1:0]  eid;
        logic [15:0] eops;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 4'b1111;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_ops", 32'(ops_count), 32'h0);
        req_valid = 4'b0000;
        rst       = 1'b0;
    endtask

    initial begin
        logic [1:0]  g;
        logic [3:0]  v;
        logic [6:0]  full;
        logic        rdy_in;
        logic        m_rv;
        logic [6:0]  m_full;
        logic [1:0]  m_id;
        logic [1:0]  exp_rr;
        logic        gnt;
        int          xfers;
        int          cyc;

        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;

        vt[0] = '{4'b0001, {6'd0, 6'd0, 6'd0, 6'd63}, {6'd0, 6'd0, 6'd0, 6'd1}, 1'b1,
                  4'b0001, 1'b1, 1'b1, 6'd0, 1'b1, 2'd0, 16'd1};
        vt[1] = '{4'b0000, 24'd0, 24'd0, 1'b1,
                  4'b0000, 1'b0, 1'b0, 6'd0, 1'b0, 2'd0, 16'd1};
        vt[2] = '{4'b1111, {6'd0, 6'd40, 6'd10, 6'd0}, {6'd0, 6'd30, 6'd20, 6'd0}, 1'b0,
                  4'b0010, 1'b1, 1'b1, 6'd30, 1'b0, 2'd1, 16'd2};
        vt[3] = '{4'b1111, {6'd0, 6'd40, 6'd10, 6'd0}, {6'd0, 6'd30, 6'd20, 6'd0}, 1'b0,
                  4'b0000, 1'b1, 1'b1, 6'd30, 1'b0, 2'd1, 16'd2};
        vt[4] = '{4'b1111, {6'd0, 6'd40, 6'd10, 6'd0}, {6'd0, 6'd30, 6'd20, 6'd0}, 1'b0,
                  4'b0000, 1'b1, 1'b1, 6'd30, 1'b0, 2'd1, 16'd2};
        vt[5] = '{4'b1111, {6'd0, 6'd40, 6'd10, 6'd0}, {6'd0, 6'd30, 6'd20, 6'd0}, 1'b1,
                  4'b0100, 1'b1, 1'b1, 6'd6, 1'b1, 2'd2, 16'd3};
        vt[6] = '{4'b0101, {6'd0, 6'd33, 6'd0, 6'd5}, {6'd0, 6'd31, 6'd0, 6'd7}, 1'b1,
                  4'b0001, 1'b1, 1'b1, 6'd12, 1'b0, 2'd0, 16'd4};
        vt[7] = '{4'b0101, {6'd0, 6'd33, 6'd0, 6'd5}, {6'd0, 6'd31, 6'd0, 6'd7}, 1'b1,
                  4'b0100, 1'b1, 1'b1, 6'd0, 1'b1, 2'd2, 16'd5};
        vt[8] = '{4'b0000, 24'd0, 24'd0, 1'b1,
                  4'b0000, 1'b0, 1'b0, 6'd0, 1'b0, 2'd0, 16'd5};

        do_reset();
        chk("rst_sum", 32'(res_sum), 32'h0);
        chk("rst_id", 32'(res_id), 32'h0);

        // Directed table: overflow, stall/hold, immediate regrant, wraparound.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            req_valid = vt[i].valid;
            req_a     = vt[i].a;
            req_b     = vt[i].b;
            res_ready = vt[i].ready;
            #1;
            chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vt[i].erdy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_res_valid", i), 32'(res_valid), 32'(vt[i].erv));
            chk($sformatf("vec%0d_ops", i), 32'(ops_count), 32'(vt[i].eops));
            if (vt[i].chk_data) begin
                chk($sformatf("vec%0d_sum", i), 32'(res_sum), 32'(vt[i].esum));
                chk($sformatf("vec%0d_cout", i), 32'(res_cout), 32'(vt[i].ecout));
                chk($sformatf("vec%0d_id", i), 32'(res_id), 32'(vt[i].eid));
            end
        end

        // Full throughput round robin from a fresh pointer.
        do_reset();
        req_a = {6'd4, 6'd3, 6'd2, 6'd1};
        req_b = {6'd40, 6'd30, 6'd20, 6'd10};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            res_ready = 1'b1;
            #1;
            g = 2'(k % 4);
            chk($sformatf("rr%0d_grant", k), 32'(req_ready), 32'(4'b0001 << g));
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d_res_valid", k), 32'(res_valid), 32'h1);
            chk($sformatf("rr%0d_id", k), 32'(res_id), 32'(g));
            chk($sformatf("rr%0d_sum", k), 32'(res_sum), 32'(11 * (k % 4 + 1)));
        end

        // Asynchronous reset mid-cycle with a pending result; pointer now at 1.
        @(negedge clk);
        req_valid = 4'b1111;
        res_ready = 1'b0;
        #2;
        chk("arst_pre_valid", 32'(res_valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("arst_res_valid", 32'(res_valid), 32'h0);
        chk("arst_ops", 32'(ops_count), 32'h0);
        chk("arst_req_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 4'b1010;
        #1;
        chk("arst_first_grant", 32'(req_ready), 32'(4'b0010));
        @(posedge clk);
        #1;
        chk("arst_res_id", 32'(res_id), 32'h1);
        chk("arst_ops_after", 32'(ops_count), 32'h1);

        // Random transfers against a small reference model.
        do_reset();
        exp_rr = 2'd0;
        m_rv   = 1'b0;
        m_full = '0;
        m_id   = '0;
        xfers  = 0;
        cyc    = 0;
        while (xfers < 10000 && cyc < 40000) begin
            cyc++;
            @(negedge clk);
            v      = 4'($urandom_range(0, 15));
            rdy_in = ($urandom_range(0, 3) != 0);
            req_valid = v;
            req_a     = 24'($urandom);
            req_b     = 24'($urandom);
            res_ready = rdy_in;
            gnt = 1'b0;
            g   = exp_rr;
            if ((!m_rv || rdy_in) && v != 4'b0000) begin
                for (int off = 0; off < 4; off++) begin
                    if (!gnt && v[(int'(exp_rr) + off) % 4]) begin
                        gnt = 1'b1;
                        g   = 2'((int'(exp_rr) + off) % 4);
                    end
                end
            end
            #1;
            chk("rand_grant", 32'(req_ready), gnt ? 32'(4'b0001 << g) : 32'h0);
            if (gnt) begin
                full   = {1'b0, req_a[g*6 +: 6]} + {1'b0, req_b[g*6 +: 6]};
                m_full = full;
                m_id   = g;
                m_rv   = 1'b1;
                exp_rr = g + 2'd1;
                xfers++;
            end else if (rdy_in) begin
                m_rv = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("rand_res_valid", 32'(res_valid), 32'(m_rv));
            if (m_rv) begin
                chk("rand_sum", 32'({res_cout, res_sum}), 32'(m_full));
                chk("rand_id", 32'(res_id), 32'(m_id));
            end
            chk("rand_ops", 32'(ops_count), 32'(xfers[15:0]));
        end
        chk("rand_xfer_budget", 32'(xfers), 32'd10000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
